// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one 1-bit full adder reused over WIDTH cycles, LSB first.
// Optional subtraction (a - b) with a 'sub' port is enabled by defining SERIAL_ADDER_SUB_EN.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             last_bit;

    full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_cout)
    );

    // Sum bits enter at the MSB and walk down, so after WIDTH shifts bit 0 lands at index 0.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_next = fa_s;
        end else begin : g_wn
            assign sum_next = {fa_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

`ifdef SERIAL_ADDER_SUB_EN
    // a - b == a + ~b + 1; cin is not used when subtracting.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    assign last_bit = (counter == CW'(WIDTH - 1));
    assign busy     = (state == S_ADD);
    assign done     = (state == S_DONE);

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make the shift chain collapse within one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the operand/sum shift registers are reset too, so a reset mid-operation
            // leaves no stale datapath contents behind.
            state   <= S_IDLE;
            counter <= '0;
            carry   <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b_load;
                        carry   <= carry_load;
                        sum_sh  <= '0;
                        counter <= '0;
                        state   <= S_ADD;
                    end
                end
                S_ADD: begin
                    sum_sh  <= sum_next;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry   <= fa_cout;
                    counter <= counter + 1'b1;
                    if (last_bit) begin
                        // 'carry' still holds the carry into the MSB on this edge.
                        sum   <= sum_next;
                        cout  <= fa_cout;
                        ovf   <= carry ^ fa_cout;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    counter <= '0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table, random ops and corner sequences.
// Define SERIAL_ADDER_SUB_EN for both files to exercise the subtraction vectors.

module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];
    vec_t vt[$];

    logic [W-1:0] held_sum;
    logic         held_cout;
    logic         held_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                                input logic vs, input logic [W-1:0] es, input logic ec,
                                input logic eo);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vc; v.sub = vs;
        v.sum = es; v.cout = ec; v.ovf = eo;
        return v;
    endfunction

    // Reference addition model: full-width add, signed overflow from operand/result signs.
    function automatic vec_t model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        logic [W:0] full;
        vec_t v;
        full = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
        v = mk(va, vb, vc, 1'b0, full[W-1:0], full[W],
               (va[W-1] == vb[W-1]) && (full[W-1] != va[W-1]));
        return v;
    endfunction

    // Drive a start at the next falling edge and record the expected result.
    task automatic issue(input vec_t v);
        exp_t e;
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
        e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf;
        sb.push_back(e);
    endtask

    // Follow one operation to its done pulse; inject_at >= 0 pulses a second start mid-op.
    task automatic wait_done(input string tag, input int inject_at);
        int   cycles;
        int   busy_n;
        bit   got;
        exp_t e;
        cycles = 0; busy_n = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            end
            if (i == inject_at) begin
                start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0;
            end else if (i == inject_at + 1) begin
                start = 1'b0;
            end
            cycles++;
            if (done) begin
                got = 1;
            end else if (busy) begin
                busy_n++;
                if (i == 2) check({tag, "_sum_hold"}, 32'(sum), 32'(held_sum));
            end
        end
        if (!got) begin
            check({tag, "_timeout"}, 32'(0), 32'(1));
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"},     32'(sum),    32'(e.sum));
            check({tag, "_cout"},    32'(cout),   32'(e.cout));
            check({tag, "_ovf"},     32'(ovf),    32'(e.ovf));
            check({tag, "_latency"}, 32'(cycles), 32'(W + 1));
            check({tag, "_busy_n"},  32'(busy_n), 32'(W));
            held_sum = e.sum; held_cout = e.cout; held_ovf = e.ovf;
            @(negedge clk);
            start = 1'b0;
            check({tag, "_idle_after"}, 32'({busy, done}), 32'(0));
        end
    endtask

    initial begin
        int seen;
        vec_t v;

        vt.push_back(mk(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1));
        vt.push_back(mk(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0));
        vt.push_back(mk(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0));
        vt.push_back(mk(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1));
        vt.push_back(mk(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0));
        vt.push_back(mk(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0));
        vt.push_back(mk(8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0));
`ifdef SERIAL_ADDER_SUB_EN
        vt.push_back(mk(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0));
        vt.push_back(mk(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1));
        vt.push_back(mk(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0));
`endif

        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 32'({busy, done, sum, cout, ovf}), 32'(0));
        reset = 1'b0;

        foreach (vt[i]) begin
            issue(vt[i]);
            wait_done($sformatf("vec%0d", i), -10);
        end

        for (int i = 0; i < 12; i++) begin
            v = model(W'($urandom), W'($urandom), 1'($urandom));
            issue(v);
            wait_done($sformatf("rnd%0d", i), -10);
        end

        // A second start three cycles into an operation must be dropped.
        issue(mk(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0));
        wait_done("ignore_start", 2);
        seen = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("ignore_no_second_op", 32'(seen), 32'(0));
        check("ignore_result_held", 32'({sum, cout, ovf}), 32'({held_sum, held_cout, held_ovf}));

        // Reset four cycles into an add aborts it without a done pulse.
        issue(mk(8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_outputs", 32'({busy, done, sum, cout, ovf}), 32'(0));
        void'(sb.pop_front());
        held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
        seen = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'(0));
        issue(mk(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1));
        wait_done("after_abort", -10);

        check("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
